// File: rtl/clock_disp_pkg.sv
// Shared definitions for the clock display scanner.
//   SEG_BLANK          : all segments off (active-low gfedcba)
//   BLINK_*            : encoding of the blink_sel input
//   DIG_*              : digit slot indices, 0 is the rightmost digit
//   ST_*               : converter sequencing FSM states
//   seg_decode()       : BCD nibble -> active-low gfedcba, >= 10 gives SEG_BLANK
package clock_disp_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    localparam logic [1:0] BLINK_NONE = 2'd0;
    localparam logic [1:0] BLINK_SEC  = 2'd1;
    localparam logic [1:0] BLINK_MIN  = 2'd2;
    localparam logic [1:0] BLINK_HOUR = 2'd3;

    localparam logic [2:0] DIG_SEC_U  = 3'd0;
    localparam logic [2:0] DIG_SEC_T  = 3'd1;
    localparam logic [2:0] DIG_MIN_U  = 3'd2;
    localparam logic [2:0] DIG_MIN_T  = 3'd3;
    localparam logic [2:0] DIG_HOUR_U = 3'd4;
    localparam logic [2:0] DIG_HOUR_T = 3'd5;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CONV_S  = 3'd1;
    localparam logic [2:0] ST_CONV_M  = 3'd2;
    localparam logic [2:0] ST_CONV_H  = 3'd3;
    localparam logic [2:0] ST_COMMIT  = 3'd4;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin60_to_bcd_seq.sv
// Sequential subtractive binary (0..63) to BCD converter.
//   clk, rst_n : clock, async active-low reset
//   start      : load value and begin converting (overrides a conversion in flight)
//   value[5:0] : binary input, sampled on start
//   done       : high in the single cycle where tens/units are final
//   tens[2:0]  : tens digit (0..6)
//   units[3:0] : units digit (0..9)
// A conversion of value v finishes (done high) tens(v)+1 cycles after start.
module bin60_to_bcd_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] value,
    output logic       done,
    output logic [2:0] tens,
    output logic [3:0] units
);

    logic [5:0] r_rem;
    logic [2:0] r_tens;
    logic       r_busy;

    // Repeated subtract-10 until the remainder is a single decimal digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= 6'd0;
            r_tens <= 3'd0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_rem  <= value;
            r_tens <= 3'd0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_rem >= 6'd10) begin
                r_rem  <= r_rem - 6'd10;
                r_tens <= r_tens + 3'd1;
            end else begin
                r_busy <= 1'b0;
            end
        end else begin
            r_busy <= 1'b0;
        end
    end

    // done is decoded from state only, so the caller can latch and restart in the same cycle.
    assign done  = r_busy && (r_rem < 6'd10);
    assign tens  = r_tens;
    assign units = r_rem[3:0];

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed common-anode 7-segment driver for the time counters.
//   clk, rst_n     : clock, async active-low reset
//   sec/min/hour   : 6-bit binary counter values, snapshotted once per frame
//   blink_sel[1:0] : field to blink (0 none, 1 sec, 2 min, 3 hour)
//   an[5:0]        : active-low one-hot digit enables, bit0 = rightmost
//   seg[6:0]       : active-low {g,f,e,d,c,b,a}
//   dp             : active-low decimal point (blinking colon on idx2/idx4)
//   frame_done     : one-cycle pulse in the last prescaler cycle of digit 5
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [5:0] hour,
    input  logic [1:0] blink_sel,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_PRE  = PW'(SCAN_DIV - 2);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1);

    // Scan timing
    logic [PW-1:0] r_presc;
    logic [2:0]    r_digit_idx;
    logic [FW-1:0] r_frame_cnt;
    logic          r_blink_phase;
    logic          w_presc_last;
    logic          w_frame_end;
    logic          w_snap;

    // Conversion
    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [5:0]    r_snap_min;
    logic [5:0]    r_snap_hour;
    logic          w_conv_start;
    logic [5:0]    w_conv_value;
    logic          w_conv_done;
    logic [2:0]    w_conv_tens;
    logic [3:0]    w_conv_units;

    // Staging and displayed digits
    logic [3:0]    r_stg_su, r_stg_mu, r_stg_hu;
    logic [2:0]    r_stg_st, r_stg_mt, r_stg_ht;
    logic [3:0]    r_disp_su, r_disp_mu, r_disp_hu;
    logic [2:0]    r_disp_st, r_disp_mt, r_disp_ht;

    // Output path
    logic [3:0]    w_nib;
    logic [1:0]    w_field;
    logic          w_blank;
    logic [5:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;
    logic [5:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame_done;

    assign w_presc_last = (r_presc == PRESC_LAST);
    assign w_frame_end  = w_presc_last && (r_digit_idx == DIG_HOUR_T);
    // Also true in the first cycle after reset release, since reset clears both counters.
    assign w_snap       = (r_presc == {PW{1'b0}}) && (r_digit_idx == DIG_SEC_U);

    // Prescaler, digit index, frame counter and blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc       <= {PW{1'b0}};
            r_digit_idx   <= DIG_SEC_U;
            r_frame_cnt   <= {FW{1'b0}};
            r_blink_phase <= 1'b0;
        end else begin
            if (w_presc_last) begin
                r_presc     <= {PW{1'b0}};
                r_digit_idx <= (r_digit_idx == DIG_HOUR_T) ? DIG_SEC_U : (r_digit_idx + 3'd1);
            end else begin
                r_presc     <= r_presc + PRESC_ONE;
            end
            if (w_frame_end) begin
                if (r_frame_cnt == FRAME_LAST) begin
                    r_frame_cnt   <= {FW{1'b0}};
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt   <= r_frame_cnt + FRAME_ONE;
                end
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
        end
    end

    // Converter sequencing: sec goes straight from the input pin into the converter on the
    // snapshot cycle (its remainder register is the sec snapshot); min/hour wait in r_snap_*.
    always_comb begin
        w_state_nxt  = r_state;
        w_conv_start = 1'b0;
        w_conv_value = sec;
        if (w_snap) begin
            w_conv_start = 1'b1;
            w_conv_value = sec;
            w_state_nxt  = ST_CONV_S;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_CONV_S: begin
                    w_conv_start = w_conv_done;
                    w_conv_value = r_snap_min;
                    w_state_nxt  = w_conv_done ? ST_CONV_M : ST_CONV_S;
                end
                ST_CONV_M: begin
                    w_conv_start = w_conv_done;
                    w_conv_value = r_snap_hour;
                    w_state_nxt  = w_conv_done ? ST_CONV_H : ST_CONV_M;
                end
                ST_CONV_H: w_state_nxt = w_conv_done ? ST_COMMIT : ST_CONV_H;
                ST_COMMIT: w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    bin60_to_bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_conv_start),
        .value (w_conv_value),
        .done  (w_conv_done),
        .tens  (w_conv_tens),
        .units (w_conv_units)
    );

    // FSM state, snapshot, staging and glitch-free commit of all six digits at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_snap_min  <= 6'd0;
            r_snap_hour <= 6'd0;
            r_stg_su    <= 4'd0;
            r_stg_st    <= 3'd0;
            r_stg_mu    <= 4'd0;
            r_stg_mt    <= 3'd0;
            r_stg_hu    <= 4'd0;
            r_stg_ht    <= 3'd0;
            r_disp_su   <= 4'd0;
            r_disp_st   <= 3'd0;
            r_disp_mu   <= 4'd0;
            r_disp_mt   <= 3'd0;
            r_disp_hu   <= 4'd0;
            r_disp_ht   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_snap) begin
                r_snap_min  <= min;
                r_snap_hour <= hour;
            end
            if (w_conv_done && (r_state == ST_CONV_S)) begin
                r_stg_st <= w_conv_tens;
                r_stg_su <= w_conv_units;
            end
            if (w_conv_done && (r_state == ST_CONV_M)) begin
                r_stg_mt <= w_conv_tens;
                r_stg_mu <= w_conv_units;
            end
            if (w_conv_done && (r_state == ST_CONV_H)) begin
                r_stg_ht <= w_conv_tens;
                r_stg_hu <= w_conv_units;
            end
            if (r_state == ST_COMMIT) begin
                r_disp_su <= r_stg_su;
                r_disp_st <= r_stg_st;
                r_disp_mu <= r_stg_mu;
                r_disp_mt <= r_stg_mt;
                r_disp_hu <= r_stg_hu;
                r_disp_ht <= r_stg_ht;
            end
        end
    end

    // Select the nibble and owning field for the current digit, apply blink and colon.
    always_comb begin
        case (r_digit_idx)
            DIG_SEC_U:  begin w_nib = r_disp_su;         w_field = BLINK_SEC;  end
            DIG_SEC_T:  begin w_nib = {1'b0, r_disp_st}; w_field = BLINK_SEC;  end
            DIG_MIN_U:  begin w_nib = r_disp_mu;         w_field = BLINK_MIN;  end
            DIG_MIN_T:  begin w_nib = {1'b0, r_disp_mt}; w_field = BLINK_MIN;  end
            DIG_HOUR_U: begin w_nib = r_disp_hu;         w_field = BLINK_HOUR; end
            DIG_HOUR_T: begin w_nib = {1'b0, r_disp_ht}; w_field = BLINK_HOUR; end
            default:    begin w_nib = 4'hF;              w_field = BLINK_NONE; end
        endcase
        w_blank = r_blink_phase && (w_field != BLINK_NONE) && (blink_sel == w_field);
        w_seg   = w_blank ? SEG_BLANK : seg_decode(w_nib);
        w_an    = ~(6'd1 << r_digit_idx);
        w_dp    = (!r_blink_phase && ((r_digit_idx == DIG_MIN_U) || (r_digit_idx == DIG_HOUR_U)))
                  ? 1'b0 : 1'b1;
    end

    // Registered pin drivers; frame_done is predicted one cycle early so it lands on the
    // terminal prescaler cycle of digit 5.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= 6'h3F;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an;
            r_seg        <= w_seg;
            r_dp         <= w_dp;
            r_frame_done <= (r_presc == PRESC_PRE) && (r_digit_idx == DIG_HOUR_T);
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
